// File: rtl/finder_center_scanner_pkg.sv
// Shared state encodings and width helpers for the finder-pattern centre scanner.
package finder_center_scanner_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SCAN     = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_ZONE_END = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    function automatic int cw_f(input int w, input int h);
        return (w > h) ? $clog2(w) : $clog2(h);
    endfunction

    function automatic int aw_f(input int w, input int h);
        return $clog2(w * h);
    endfunction

    function automatic int nw_f(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    function automatic int idx_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/finder_center_scanner_if.sv
// Scan request, pixel memory and result bus between the requester and the scanner.
interface finder_center_scanner_if
    import finder_center_scanner_pkg::*;
#(
    parameter int WIDTH       = 480,
    parameter int HEIGHT      = 480,
    parameter int MAX_CENTERS = 3
);
    localparam int CW  = cw_f(WIDTH, HEIGHT);
    localparam int AW  = aw_f(WIDTH, HEIGHT);
    localparam int CNW = $clog2(MAX_CENTERS + 1);

    logic                            start_in;
    logic                            pixel_in;
    logic [AW-1:0]                   address_out;
    logic [MAX_CENTERS-1:0][CW-1:0]  centers_x;
    logic [MAX_CENTERS-1:0][CW-1:0]  centers_y;
    logic [CNW-1:0]                  center_count;
    logic                            busy_out;
    logic                            done_out;
    logic                            not_found_out;

    modport master (
        output start_in, pixel_in,
        input  address_out, centers_x, centers_y, center_count, busy_out, done_out, not_found_out
    );

    modport slave (
        input  start_in, pixel_in,
        output address_out, centers_x, centers_y, center_count, busy_out, done_out, not_found_out
    );

endinterface

// File: rtl/finder_center_scanner_zone_bounds_mux.sv
// Selects the inclusive pixel window of the current zone and judges whether
// the zone's black/white tally is dark enough to hold a finder centre.
module zone_bounds_mux
    import finder_center_scanner_pkg::*;
#(
    parameter int WIDTH      = 480,
    parameter int HEIGHT     = 480,
    parameter int ZONES_X    = 3,
    parameter int ZONES_Y    = 3,
    parameter int THRESH_NUM = 3,
    parameter int THRESH_DEN = 4,
    localparam int CW  = cw_f(WIDTH, HEIGHT),
    localparam int ZXW = idx_w_f(ZONES_X),
    localparam int ZYW = idx_w_f(ZONES_Y),
    localparam int NW  = nw_f(WIDTH, HEIGHT)
)(
    input  logic [ZXW-1:0]             zx_i,
    input  logic [ZYW-1:0]             zy_i,
    input  logic [ZONES_X-2:0][CW-1:0] bound_x_i,
    input  logic [ZONES_Y-2:0][CW-1:0] bound_y_i,
    input  logic [NW-1:0]              black_i,
    input  logic [NW-1:0]              white_i,
    output logic [CW-1:0]              xmin_o,
    output logic [CW-1:0]              xmax_o,
    output logic [CW-1:0]              ymin_o,
    output logic [CW-1:0]              ymax_o,
    output logic                       skip_o,
    output logic                       pass_o
);
    // Wide enough that count * max(NUM, DEN) of a doubled count never wraps.
    localparam int PW = NW + $clog2(THRESH_NUM + THRESH_DEN + 1) + 1;

    logic [ZONES_X:0][CW-1:0] bx_s;
    logic [ZONES_Y:0][CW-1:0] by_s;
    logic [PW-1:0]            total_s;

    // Boundary tables with the image edges fixed at both ends, then pick this zone.
    always_comb begin
        bx_s   = '0;
        by_s   = '0;
        xmin_o = '0;
        xmax_o = '0;
        ymin_o = '0;
        ymax_o = '0;
        for (int i = 0; i <= ZONES_X; i++) begin
            if (i == 0) begin
                bx_s[i] = '0;
            end else if (i == ZONES_X) begin
                bx_s[i] = CW'(WIDTH - 1);
            end else begin
                bx_s[i] = bound_x_i[i-1];
            end
        end
        for (int j = 0; j <= ZONES_Y; j++) begin
            if (j == 0) begin
                by_s[j] = '0;
            end else if (j == ZONES_Y) begin
                by_s[j] = CW'(HEIGHT - 1);
            end else begin
                by_s[j] = bound_y_i[j-1];
            end
        end
        for (int i = 0; i < ZONES_X; i++) begin
            if (ZXW'(i) == zx_i) begin
                xmin_o = bx_s[i];
                xmax_o = bx_s[i+1];
            end else begin
                xmin_o = xmin_o;
            end
        end
        for (int j = 0; j < ZONES_Y; j++) begin
            if (ZYW'(j) == zy_i) begin
                ymin_o = by_s[j];
                ymax_o = by_s[j+1];
            end else begin
                ymin_o = ymin_o;
            end
        end
    end

    assign skip_o  = (xmin_o > xmax_o) || (ymin_o > ymax_o);
    assign total_s = PW'(black_i) + PW'(white_i);
    assign pass_o  = (total_s != {PW{1'b0}}) &&
                     ((PW'(black_i) * PW'(THRESH_DEN)) >= (total_s * PW'(THRESH_NUM)));

endmodule

// File: rtl/finder_center_scanner.sv
// Walks image zones, reads every candidate pixel, and records the midpoint of
// each zone whose candidates are mostly black, stopping at MAX_CENTERS.
module finder_center_scanner
    import finder_center_scanner_pkg::*;
#(
    parameter int WIDTH        = 480,
    parameter int HEIGHT       = 480,
    parameter int ZONES_X      = 3,
    parameter int ZONES_Y      = 3,
    parameter int MAX_CENTERS  = 3,
    parameter int READ_LATENCY = 2,
    parameter int THRESH_NUM   = 3,
    parameter int THRESH_DEN   = 4
)(
    input  logic                                         clk_in,
    input  logic                                         rst_n_in,
    finder_center_scanner_if.slave                       bus,
    input  logic [WIDTH-1:0]                             horz_patterns,
    input  logic [HEIGHT-1:0]                            vert_patterns,
    input  logic [ZONES_X-2:0][cw_f(WIDTH, HEIGHT)-1:0]  bound_x,
    input  logic [ZONES_Y-2:0][cw_f(WIDTH, HEIGHT)-1:0]  bound_y
);
    localparam int CW  = cw_f(WIDTH, HEIGHT);
    localparam int AW  = aw_f(WIDTH, HEIGHT);
    localparam int NW  = nw_f(WIDTH, HEIGHT);
    localparam int ZXW = idx_w_f(ZONES_X);
    localparam int ZYW = idx_w_f(ZONES_Y);
    localparam int CNW = $clog2(MAX_CENTERS + 1);
    localparam int WW  = $clog2(READ_LATENCY + 1);

    logic [2:0]                     state_q, state_d;
    logic [ZXW-1:0]                 zx_q, zx_d, nzx_s;
    logic [ZYW-1:0]                 zy_q, zy_d, nzy_s;
    logic [CW-1:0]                  x_q, x_d, y_q, y_d;
    logic [CW-1:0]                  fx_q, fx_d, fy_q, fy_d, lx_q, lx_d, ly_q, ly_d;
    logic                           zstart_q, zstart_d, found_q, found_d;
    logic [WW-1:0]                  wcnt_q, wcnt_d;
    logic [NW-1:0]                  white_q, white_d, black_q, black_d;
    logic [AW-1:0]                  addr_q, addr_d, addr_s;
    logic [MAX_CENTERS-1:0][CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [CNW-1:0]                 count_q, count_d;
    logic                           busy_q, busy_d, done_q, done_d, nf_q, nf_d;

    logic [CW-1:0] xmin_s, xmax_s, ymin_s, ymax_s, step_x_s, step_y_s;
    logic [CW:0]   sum_x_s, sum_y_s;
    logic [2:0]    step_state_s;
    logic          skip_s, pass_s, cand_s, zone_last_s, row_end_s;

    zone_bounds_mux #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ZONES_X(ZONES_X), .ZONES_Y(ZONES_Y),
        .THRESH_NUM(THRESH_NUM), .THRESH_DEN(THRESH_DEN)
    ) u_bounds (
        .zx_i(zx_q), .zy_i(zy_q), .bound_x_i(bound_x), .bound_y_i(bound_y),
        .black_i(black_q), .white_i(white_q),
        .xmin_o(xmin_s), .xmax_o(xmax_s), .ymin_o(ymin_s), .ymax_o(ymax_s),
        .skip_o(skip_s), .pass_o(pass_s)
    );

    assign cand_s       = horz_patterns[x_q] & vert_patterns[y_q];
    assign addr_s       = AW'(x_q) + AW'(y_q) * AW'(WIDTH);
    assign row_end_s    = (x_q == xmax_s);
    assign step_state_s = (row_end_s && (y_q == ymax_s)) ? ST_ZONE_END : ST_SCAN;
    assign step_x_s     = row_end_s ? xmin_s : x_q + CW'(1);
    assign step_y_s     = row_end_s ? y_q + CW'(1) : y_q;
    assign zone_last_s  = (zx_q == ZXW'(ZONES_X - 1)) && (zy_q == ZYW'(ZONES_Y - 1));
    assign nzx_s        = (zx_q == ZXW'(ZONES_X - 1)) ? {ZXW{1'b0}} : zx_q + ZXW'(1);
    assign nzy_s        = (zx_q == ZXW'(ZONES_X - 1)) ? zy_q + ZYW'(1) : zy_q;
    assign sum_x_s      = {1'b0, fx_q} + {1'b0, lx_q};
    assign sum_y_s      = {1'b0, fy_q} + {1'b0, ly_q};

    // Next-state logic; a zone spends one cycle loading its start point (or being skipped).
    always_comb begin
        state_d = state_q;  zx_d = zx_q;  zy_d = zy_q;  x_d = x_q;  y_d = y_q;
        fx_d = fx_q;  fy_d = fy_q;  lx_d = lx_q;  ly_d = ly_q;
        zstart_d = zstart_q;  found_d = found_q;  wcnt_d = wcnt_q;
        white_d = white_q;  black_d = black_q;  addr_d = {AW{1'b0}};
        cx_d = cx_q;  cy_d = cy_q;  count_d = count_q;
        busy_d = busy_q;  done_d = 1'b0;  nf_d = nf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    cx_d = '0;  cy_d = '0;  count_d = {CNW{1'b0}};  nf_d = 1'b0;
                    busy_d = 1'b1;  zx_d = {ZXW{1'b0}};  zy_d = {ZYW{1'b0}};
                    zstart_d = 1'b1;  state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (zstart_q) begin
                    if (!skip_s) begin
                        x_d = xmin_s;  y_d = ymin_s;  zstart_d = 1'b0;  found_d = 1'b0;
                        white_d = {NW{1'b0}};  black_d = {NW{1'b0}};
                    end else if (zone_last_s) begin
                        state_d = ST_DONE;  done_d = 1'b1;  busy_d = 1'b0;
                        nf_d = (count_d < CNW'(MAX_CENTERS));
                    end else begin
                        zx_d = nzx_s;  zy_d = nzy_s;
                    end
                end else if (cand_s) begin
                    if (!found_q) begin
                        fx_d = x_q;  fy_d = y_q;
                    end else begin
                        fx_d = fx_q;  fy_d = fy_q;
                    end
                    found_d = 1'b1;  lx_d = x_q;  ly_d = y_q;
                    addr_d = addr_s;  wcnt_d = WW'(1);  state_d = ST_WAIT;
                end else begin
                    state_d = step_state_s;  x_d = step_x_s;  y_d = step_y_s;
                end
            end
            ST_WAIT: begin
                if (wcnt_q < WW'(READ_LATENCY)) begin
                    addr_d = addr_s;  wcnt_d = wcnt_q + WW'(1);
                end else begin
                    if (bus.pixel_in) begin
                        white_d = white_q + NW'(1);
                    end else begin
                        black_d = black_q + NW'(1);
                    end
                    state_d = step_state_s;  x_d = step_x_s;  y_d = step_y_s;
                end
            end
            ST_ZONE_END: begin
                if (pass_s) begin
                    for (int i = 0; i < MAX_CENTERS; i++) begin
                        if (CNW'(i) == count_q) begin
                            cx_d[i] = sum_x_s[CW:1];
                            cy_d[i] = sum_y_s[CW:1];
                        end else begin
                            cx_d[i] = cx_q[i];
                        end
                    end
                    count_d = count_q + CNW'(1);
                end else begin
                    count_d = count_q;
                end
                if ((count_d == CNW'(MAX_CENTERS)) || zone_last_s) begin
                    state_d = ST_DONE;  done_d = 1'b1;  busy_d = 1'b0;
                    nf_d = (count_d < CNW'(MAX_CENTERS));
                end else begin
                    zx_d = nzx_s;  zy_d = nzy_s;  zstart_d = 1'b1;  state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything including a pending read.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;  zx_q <= '0;  zy_q <= '0;  x_q <= '0;  y_q <= '0;
            fx_q <= '0;  fy_q <= '0;  lx_q <= '0;  ly_q <= '0;
            zstart_q <= 1'b0;  found_q <= 1'b0;  wcnt_q <= '0;
            white_q <= '0;  black_q <= '0;  addr_q <= '0;
            cx_q <= '0;  cy_q <= '0;  count_q <= '0;
            busy_q <= 1'b0;  done_q <= 1'b0;  nf_q <= 1'b0;
        end else begin
            state_q <= state_d;  zx_q <= zx_d;  zy_q <= zy_d;  x_q <= x_d;  y_q <= y_d;
            fx_q <= fx_d;  fy_q <= fy_d;  lx_q <= lx_d;  ly_q <= ly_d;
            zstart_q <= zstart_d;  found_q <= found_d;  wcnt_q <= wcnt_d;
            white_q <= white_d;  black_q <= black_d;  addr_q <= addr_d;
            cx_q <= cx_d;  cy_q <= cy_d;  count_q <= count_d;
            busy_q <= busy_d;  done_q <= done_d;  nf_q <= nf_d;
        end
    end

    assign bus.address_out   = addr_q;
    assign bus.centers_x     = cx_q;
    assign bus.centers_y     = cy_q;
    assign bus.center_count  = count_q;
    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.not_found_out = nf_q;

endmodule

// File: tb/tb_finder_center_scanner.sv
// Scoreboard bench: a zone-by-zone reference model predicts each scan result,
// and a monitor compares it when done_out fires.
module tb_finder_center_scanner;
    localparam int W = 16, H = 16, MAXC = 3, RL = 2, CW = 4, TN = 3, TD = 4;

    typedef struct {
        int cnt;
        int cx[3];
        int cy[3];
        int nf;
        int acyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [W-1:0]        horz;
    logic [H-1:0]        vert;
    logic [1:0][CW-1:0]  bound_x, bound_y;
    bit   [W*H-1:0]      mem;

    int   errors = 0, checks = 0;
    int   acyc_mon = 0, hold151 = 0, done_cyc = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    finder_center_scanner_if #(.WIDTH(W), .HEIGHT(H), .MAX_CENTERS(MAXC)) bus();

    finder_center_scanner #(
        .WIDTH(W), .HEIGHT(H), .ZONES_X(3), .ZONES_Y(3), .MAX_CENTERS(MAXC),
        .READ_LATENCY(RL), .THRESH_NUM(TN), .THRESH_DEN(TD)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .bus(bus.slave),
        .horz_patterns(horz), .vert_patterns(vert), .bound_x(bound_x), .bound_y(bound_y)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: visit zones row-major, tally candidates, apply the dark-fraction rule.
    function automatic exp_t model();
        exp_t e;
        int bxa[4], bya[4];
        int b, w, fx, fy, lx, ly;
        bit stop;
        stop = 1'b0;
        e.cnt = 0; e.nf = 0; e.acyc = 0;
        for (int i = 0; i < 3; i++) begin e.cx[i] = 0; e.cy[i] = 0; end
        bxa[0] = 0; bxa[1] = int'(bound_x[0]); bxa[2] = int'(bound_x[1]); bxa[3] = W - 1;
        bya[0] = 0; bya[1] = int'(bound_y[0]); bya[2] = int'(bound_y[1]); bya[3] = H - 1;
        for (int zy = 0; zy < 3; zy++) begin
            for (int zx = 0; zx < 3; zx++) begin
                if (!stop && bxa[zx] <= bxa[zx+1] && bya[zy] <= bya[zy+1]) begin
                    b = 0; w = 0; fx = -1; fy = 0; lx = 0; ly = 0;
                    for (int y = bya[zy]; y <= bya[zy+1]; y++) begin
                        for (int x = bxa[zx]; x <= bxa[zx+1]; x++) begin
                            if (horz[x] && vert[y]) begin
                                if (fx < 0) begin fx = x; fy = y; end
                                lx = x; ly = y;
                                if (mem[x + W*y]) w++; else b++;
                                if (x + W*y != 0) e.acyc += RL;
                            end
                        end
                    end
                    if ((b + w) > 0 && b * TD >= (b + w) * TN) begin
                        e.cx[e.cnt] = (fx + lx) / 2;
                        e.cy[e.cnt] = (fy + ly) / 2;
                        e.cnt++;
                        if (e.cnt == MAXC) stop = 1'b1;
                    end
                end
            end
        end
        e.nf = (e.cnt < MAXC) ? 1 : 0;
        return e;
    endfunction

    // Memory with the pixel driven mid-cycle from the currently presented address.
    always @(negedge clk) bus.pixel_in = mem[bus.address_out];

    // Monitor: count read cycles and compare against the scoreboard on done_out.
    always @(negedge clk) begin
        if (!rst_n) begin
            acyc_mon = 0;
        end else begin
            if (bus.busy_out && bus.address_out != 0) acyc_mon++;
            if (bus.address_out == 8'd151) hold151++;
            if (bus.done_out) begin
                exp_t e;
                done_cyc++;
                chk("sb_depth", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("center_count", int'(bus.center_count), e.cnt);
                    for (int i = 0; i < 3; i++) begin
                        chk($sformatf("center_x%0d", i), int'(bus.centers_x[i]), e.cx[i]);
                        chk($sformatf("center_y%0d", i), int'(bus.centers_y[i]), e.cy[i]);
                    end
                    chk("not_found", int'(bus.not_found_out), e.nf);
                    chk("read_cycles", acyc_mon, e.acyc);
                    chk("busy_at_done", int'(bus.busy_out), 0);
                end
                acyc_mon = 0;
            end
        end
    end

    task automatic run_scan(input bit dbl_start);
        sb_q.push_back(model());
        done_cyc = 0;
        @(negedge clk) bus.start_in = 1'b1;
        @(negedge clk) bus.start_in = 1'b0;
        if (dbl_start) begin
            repeat (4) @(negedge clk);
            bus.start_in = 1'b1;
            @(negedge clk) bus.start_in = 1'b0;
        end
        for (int c = 0; c < 20000 && sb_q.size() != 0; c++) @(negedge clk);
        chk("scan_complete", sb_q.size(), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cyc, 1);
    endtask

    initial begin
        bus.start_in = 1'b0;
        horz = '0; vert = '0; mem = '0;
        bound_x[0] = 4'd5; bound_x[1] = 4'd10;
        bound_y[0] = 4'd5; bound_y[1] = 4'd10;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy_out), 0);
        chk("rst_done", int'(bus.done_out), 0);
        chk("rst_count", int'(bus.center_count), 0);
        chk("rst_nf", int'(bus.not_found_out), 0);
        chk("rst_addr", int'(bus.address_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single small dark block in zone (0,0)
        horz[3:1] = 3'b111; vert[3:1] = 3'b111;
        run_scan(1'b0);

        // Three dark zones: early stop after zone (0,2)
        horz = '0; vert = '0;
        horz[1] = 1'b1; horz[2] = 1'b1; horz[12] = 1'b1; horz[13] = 1'b1;
        vert[1] = 1'b1; vert[2] = 1'b1; vert[12] = 1'b1; vert[13] = 1'b1;
        run_scan(1'b0);

        // Threshold boundary: 3 of 4 black passes, 2 of 4 does not
        horz = '0; vert = '0; horz[2:1] = 2'b11; vert[2:1] = 2'b11;
        mem[1 + W*1] = 1'b1;
        run_scan(1'b0);
        mem[2 + W*2] = 1'b1;
        run_scan(1'b0);

        // Lone candidate at (7,9): address 151 for exactly the read latency
        horz = '0; vert = '0; mem = '0; horz[7] = 1'b1; vert[9] = 1'b1;
        hold151 = 0;
        run_scan(1'b0);
        chk("addr151_hold", hold151, RL);

        // Reset while a read is outstanding
        horz = '0; vert = '0; horz[3:1] = 3'b111; vert[3:1] = 3'b111;
        done_cyc = 0;
        @(negedge clk) bus.start_in = 1'b1;
        @(negedge clk) bus.start_in = 1'b0;
        for (int c = 0; c < 500 && bus.address_out == 0; c++) @(negedge clk);
        chk("wait_reached", int'(bus.address_out != 0), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy_out), 0);
        chk("midrst_done", int'(bus.done_out), 0);
        chk("midrst_addr", int'(bus.address_out), 0);
        chk("midrst_count", int'(bus.center_count), 0);
        chk("midrst_nf", int'(bus.not_found_out), 0);
        chk("midrst_cx", int'(bus.centers_x), 0);
        chk("midrst_cy", int'(bus.centers_y), 0);
        repeat (2) @(negedge clk);
        chk("midrst_no_done", done_cyc, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(1'b0);

        // Restart while busy is ignored
        horz = '0; vert = '0;
        horz[1] = 1'b1; horz[2] = 1'b1; horz[12] = 1'b1; horz[13] = 1'b1;
        vert[1] = 1'b1; vert[2] = 1'b1; vert[12] = 1'b1; vert[13] = 1'b1;
        run_scan(1'b1);

        // Inverted column bounds skip the middle column of zones
        bound_x[0] = 4'd9; bound_x[1] = 4'd4;
        horz = '0; vert = '0; horz[2] = 1'b1; horz[6] = 1'b1; horz[12] = 1'b1; vert[2] = 1'b1;
        run_scan(1'b0);

        // Randomised flags, pixels and bounds
        for (int t = 0; t < 10; t++) begin
            bound_x[0] = 4'($urandom_range(15, 0)); bound_x[1] = 4'($urandom_range(15, 0));
            bound_y[0] = 4'($urandom_range(15, 0)); bound_y[1] = 4'($urandom_range(15, 0));
            for (int i = 0; i < W; i++) horz[i] = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < H; i++) vert[i] = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < W*H; i++) mem[i] = ($urandom_range(5, 0) == 0);
            run_scan(t[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
